// File: rtl/vidac_pkg.sv
// Shared definitions for the video accelerator command path: opcodes, command
// memory window, packet lengths and byte-level packet encoding.
package vidac_pkg;

    localparam logic [2:0] OP_NONE        = 3'd0;
    localparam logic [2:0] OP_LINE        = 3'd1;
    localparam logic [2:0] OP_BLOCK       = 3'd2;
    localparam logic [2:0] OP_BLOCK_FILL  = 3'd3;
    localparam logic [2:0] OP_POLY        = 3'd4;
    localparam logic [2:0] OP_CIRCLE      = 3'd5;
    localparam logic [2:0] OP_CIRCLE_FILL = 3'd6;
    localparam logic [2:0] OP_BLOCK_TEX   = 3'd7;

    localparam logic [17:0] ACMD_BASE = 18'h20000;
    localparam logic [17:0] ACMD_LAST = 18'h3FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT,
        ST_TERM,
        ST_KICK,
        ST_WAITB,
        ST_WAITD
    } feed_state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] x1;
        logic [15:0] y1;
        logic [15:0] x2;
        logic [15:0] y2;
        logic [7:0]  c;
    } vd_req_t;

    // Zero marks an opcode the feeder cannot encode (OP_NONE, OP_BLOCK_TEX).
    function automatic logic [3:0] pkt_len(input logic [2:0] op);
        case (op)
            OP_LINE, OP_BLOCK, OP_BLOCK_FILL: return 4'd10;
            OP_POLY:                          return 4'd6;
            OP_CIRCLE, OP_CIRCLE_FILL:        return 4'd8;
            default:                          return 4'd0;
        endcase
    endfunction

    // Byte idx of a packet: opcode, then 16-bit words low byte first, then colour.
    function automatic logic [7:0] pkt_byte(input vd_req_t r, input logic [3:0] idx);
        logic [2:0]  nw;
        logic [3:0]  im1;
        logic [2:0]  wsel;
        logic [15:0] wd;
        im1  = idx - 4'd1;
        wsel = im1[3:1];
        case (r.op)
            OP_POLY: begin
                nw = 3'd2;
                wd = (wsel == 3'd0) ? r.x2 : r.y2;
            end
            OP_CIRCLE, OP_CIRCLE_FILL: begin
                nw = 3'd3;
                case (wsel)
                    3'd0:    wd = r.x1;
                    3'd1:    wd = r.y1;
                    default: wd = r.y2;
                endcase
            end
            default: begin
                nw = 3'd4;
                case (wsel)
                    3'd0:    wd = r.x1;
                    3'd1:    wd = r.y1;
                    3'd2:    wd = r.x2;
                    default: wd = r.y2;
                endcase
            end
        endcase
        if (idx == 4'd0)
            return {5'd0, r.op};
        else if (idx == {nw, 1'b1})
            return r.c;
        else
            return im1[0] ? wd[15:8] : wd[7:0];
    endfunction

endpackage

// File: rtl/vidac_feeder_if.sv
// Host request channel into the accelerator command feeder.
interface vidac_feeder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_x1;
    logic [15:0] req_y1;
    logic [15:0] req_x2;
    logic [15:0] req_y2;
    logic [7:0]  req_c;

    modport master (
        output req_valid, req_op, req_x1, req_y1, req_x2, req_y2, req_c,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_x1, req_y1, req_x2, req_y2, req_c,
        output req_ready
    );
endinterface

// File: rtl/vidac_feeder.sv
// Builds an accelerator command list in video memory from host requests and
// hands it to the accelerator on kick, waiting for it to finish.
module vidac_feeder
    import vidac_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    vidac_feeder_if.slave   req,
    input  logic            kick,
    output logic            busy,
    output logic            done,
    output logic            err_ovf,
    output logic            err_op,
    output logic [16:0]     level,
    output logic            vd_cmd,
    input  logic            vd_bsy,
    output logic            own,
    output logic [17:0]     a,
    output logic [7:0]      o,
    output logic            w
);

    feed_state_t state, state_d;
    logic [17:0] ptr, ptr_d;
    logic [3:0]  idx, idx_d;
    vd_req_t     lat, lat_d;
    logic        kick_pend, kick_pend_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        eop_q, eop_d;

    logic        accept;
    logic        op_ok;
    logic        fits;
    logic [3:0]  req_len;
    logic [18:0] end_addr;

    assign req_len       = pkt_len(req.req_op);
    assign op_ok         = (req_len != 4'd0);
    // One byte past the packet is kept free for the list terminator.
    assign end_addr      = {1'b0, ptr} + {15'd0, req_len};
    assign fits          = (end_addr <= {1'b0, ACMD_LAST});
    assign req.req_ready = reset_n && (state == ST_IDLE) && !kick_pend;
    assign accept        = req.req_valid && req.req_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= ACMD_BASE;
            idx       <= '0;
            lat       <= '0;
            kick_pend <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            eop_q     <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            idx       <= idx_d;
            lat       <= lat_d;
            kick_pend <= kick_pend_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            eop_q     <= eop_d;
        end
    end

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        idx_d       = idx;
        lat_d       = lat;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        eop_d       = eop_q;
        kick_pend_d = kick_pend | (kick && (state != ST_WAITB) && (state != ST_WAITD));
        case (state)
            ST_IDLE: begin
                // A request wins over a kick; a same-cycle kick stays pending.
                if (accept) begin
                    if (!op_ok) begin
                        eop_d = 1'b1;
                    end else if (!fits) begin
                        ovf_d = 1'b1;
                    end else begin
                        lat_d = '{op: req.req_op, x1: req.req_x1, y1: req.req_y1,
                                  x2: req.req_x2, y2: req.req_y2, c: req.req_c};
                        idx_d   = '0;
                        state_d = ST_EMIT;
                    end
                end else if (kick_pend) begin
                    kick_pend_d = 1'b0;
                    if (ptr == ACMD_BASE)
                        done_d = 1'b1;
                    else
                        state_d = ST_TERM;
                end
            end
            ST_EMIT: begin
                ptr_d = ptr + 18'd1;
                idx_d = idx + 4'd1;
                if (idx == pkt_len(lat.op) - 4'd1)
                    state_d = ST_IDLE;
            end
            ST_TERM: state_d = ST_KICK;
            ST_KICK: begin
                if (!vd_bsy)
                    state_d = ST_WAITB;
            end
            ST_WAITB: begin
                if (vd_bsy)
                    state_d = ST_WAITD;
            end
            ST_WAITD: begin
                if (!vd_bsy) begin
                    state_d = ST_IDLE;
                    ptr_d   = ACMD_BASE;
                    ovf_d   = 1'b0;
                    eop_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        own     = (state == ST_EMIT) || (state == ST_TERM);
        w       = own;
        a       = ptr;
        o       = '0;
        vd_cmd  = (state == ST_KICK) && !vd_bsy;
        done    = done_q;
        err_ovf = ovf_q;
        err_op  = eop_q;
        level   = ptr[16:0] - ACMD_BASE[16:0];
        if (state == ST_EMIT)
            o = pkt_byte(lat, idx);
    end

endmodule

// File: tb/tb_vidac_feeder.sv
// Scoreboard bench for vidac_feeder: expected memory writes are queued as
// requests are driven and retired by a write monitor; an accelerator model answers kicks.
module tb_vidac_feeder;
    import vidac_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        kick = 1'b0;
    logic        vd_bsy = 1'b0;
    logic        busy, done, err_ovf, err_op, vd_cmd, own, w;
    logic [16:0] level;
    logic [17:0] a;
    logic [7:0]  o;

    vidac_feeder_if rq();

    vidac_feeder dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (rq),
        .kick    (kick),
        .busy    (busy),
        .done    (done),
        .err_ovf (err_ovf),
        .err_op  (err_op),
        .level   (level),
        .vd_cmd  (vd_cmd),
        .vd_bsy  (vd_bsy),
        .own     (own),
        .a       (a),
        .o       (o),
        .w       (w)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [17:0] a;
        logic [7:0]  d;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          cmd_cnt = 0;
    int          acc_cnt = 0;
    wr_t         sb[$];
    wr_t         mon_e;
    logic [17:0] exp_ptr = ACMD_BASE;
    bit          acc_start;

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (w === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: a=%h o=%h, required no write", a, o);
            end else begin
                mon_e = sb.pop_front();
                if (a !== mon_e.a || o !== mon_e.d) begin
                    errors++;
                    $display("FAIL write_data: a=%h o=%h, required a=%h o=%h", a, o, mon_e.a, mon_e.d);
                end
            end
            checks++;
            if (own !== 1'b1) begin
                errors++;
                $display("FAIL own_during_write: own=%b, required 1", own);
            end
        end
    end

    // Accelerator model: goes busy the cycle after a start pulse, for 50 cycles.
    always @(negedge clock) begin
        if (!reset_n) begin
            acc_cnt = 0;
            vd_bsy  = 1'b0;
        end else begin
            acc_start = 1'b0;
            if (vd_cmd === 1'b1) begin
                checks++;
                if (vd_bsy !== 1'b0) begin
                    errors++;
                    $display("FAIL cmd_while_busy: vd_bsy=%b, required 0", vd_bsy);
                end
                checks++;
                if (sb.size() != 0) begin
                    errors++;
                    $display("FAIL cmd_before_list_done: pending writes=%0d, required 0", sb.size());
                end
                cmd_cnt++;
                acc_start = 1'b1;
            end
            if (acc_cnt > 0) begin
                vd_bsy = 1'b1;
                acc_cnt--;
            end else begin
                vd_bsy = 1'b0;
            end
            if (acc_start)
                acc_cnt = 50;
        end
    end

    task automatic sb_push(input logic [7:0] d);
        wr_t e;
        e.a = exp_ptr;
        e.d = d;
        sb.push_back(e);
        exp_ptr++;
    endtask

    task automatic push_term();
        wr_t e;
        e.a = exp_ptr;
        e.d = 8'h00;
        sb.push_back(e);
    endtask

    task automatic push_pkt(input logic [2:0] op, input logic [15:0] x1, y1, x2, y2,
                            input logic [7:0] c);
        logic [15:0] wl[$];
        case (op)
            3'd1, 3'd2, 3'd3: wl = '{x1, y1, x2, y2};
            3'd4:             wl = '{x2, y2};
            default:          wl = '{x1, y1, y2};
        endcase
        sb_push({5'd0, op});
        foreach (wl[i]) begin
            sb_push(wl[i][7:0]);
            sb_push(wl[i][15:8]);
        end
        sb_push(c);
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [2:0] op, input logic [15:0] x1, y1, x2, y2,
                        input logic [7:0] c, input logic with_kick);
        checks++;
        if (rq.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_before_send: got %b, required 1", rq.req_ready);
        end
        rq.req_valid = 1'b1;
        rq.req_op    = op;
        rq.req_x1    = x1;
        rq.req_y1    = y1;
        rq.req_x2    = x2;
        rq.req_y2    = y2;
        rq.req_c     = c;
        kick         = with_kick;
        @(negedge clock);
        rq.req_valid = 1'b0;
        kick         = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit got);
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic finish_kick(input int cmd0, input int exp_cmds);
        checks++;
        if (cmd_cnt - cmd0 !== exp_cmds) begin
            errors++;
            $display("FAIL kick_cmd_count: got %0d, required %0d", cmd_cnt - cmd0, exp_cmds);
        end
        checks++;
        if (level !== 17'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL kick_end_state: level=%0d busy=%b, required 0 0", level, busy);
        end
        checks++;
        if (err_ovf !== 1'b0 || err_op !== 1'b0) begin
            errors++;
            $display("FAIL kick_err_clear: err_ovf=%b err_op=%b, required 0 0", err_ovf, err_op);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: done=%b, required 0", done);
        end
        exp_ptr = ACMD_BASE;
    endtask

    task automatic do_kick(input bit nonempty);
        int cmd0;
        bit got;
        cmd0 = cmd_cnt;
        if (nonempty)
            push_term();
        kick = 1'b1;
        @(negedge clock);
        kick = 1'b0;
        if (!nonempty) begin
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL empty_kick_early_done: done=%b, required 0", done);
            end
            @(negedge clock);
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL empty_kick_done: done=%b, required 1", done);
            end
        end else begin
            wait_done(200, got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL kick_done_timeout: done=%b, required 1 within 200 cycles", done);
            end
        end
        finish_kick(cmd0, nonempty ? 1 : 0);
    endtask

    task automatic test_reset();
        rq.req_valid = 1'b0;
        rq.req_op    = '0;
        rq.req_x1    = '0;
        rq.req_y1    = '0;
        rq.req_x2    = '0;
        rq.req_y2    = '0;
        rq.req_c     = '0;
        reset_n      = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (rq.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_ready: got %b, required 0", rq.req_ready);
        end
        checks++;
        if ({busy, done, err_ovf, err_op, vd_cmd, own, w} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: busy,done,ovf,op,cmd,own,w=%b, required 0000000",
                     {busy, done, err_ovf, err_op, vd_cmd, own, w});
        end
        checks++;
        if (a !== 18'h20000 || o !== 8'h00 || level !== 17'd0) begin
            errors++;
            $display("FAIL reset_bus: a=%h o=%h level=%0d, required 20000 00 0", a, o, level);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (rq.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, required 1", rq.req_ready);
        end
        @(negedge clock);
    endtask

    task automatic test_empty_kick();
        do_kick(1'b0);
    endtask

    task automatic test_line();
        logic [7:0] bytes[10] = '{8'h01, 8'h0A, 8'h00, 8'h14, 8'h00, 8'h2C, 8'h01, 8'h05, 8'h00, 8'h0F};
        foreach (bytes[i])
            sb_push(bytes[i]);
        send(3'd1, 16'd10, 16'd20, 16'd300, 16'd5, 8'h0F, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (w !== 1'b1) begin
                errors++;
                $display("FAIL line_consecutive: cycle %0d w=%b, required 1", i, w);
            end
            @(negedge clock);
        end
        checks++;
        if (w !== 1'b0 || busy !== 1'b0 || level !== 17'd10 || sb.size() != 0) begin
            errors++;
            $display("FAIL line_end: w=%b busy=%b level=%0d pending=%0d, required 0 0 10 0",
                     w, busy, level, sb.size());
        end
        do_kick(1'b1);
    endtask

    task automatic test_circle_kick();
        logic [7:0] bytes[8] = '{8'h05, 8'hA0, 8'h00, 8'h64, 8'h00, 8'h28, 8'h00, 8'h04};
        foreach (bytes[i])
            sb_push(bytes[i]);
        send(3'd5, 16'd160, 16'd100, 16'd0, 16'd40, 8'h04, 1'b0);
        repeat (8) @(negedge clock);
        checks++;
        if (level !== 17'd8 || exp_ptr !== 18'h20008) begin
            errors++;
            $display("FAIL circle_level: level=%0d, required 8", level);
        end
        do_kick(1'b1);
    endtask

    task automatic test_poly_with_kick();
        int cmd0;
        bit got;
        cmd0 = cmd_cnt;
        push_pkt(3'd4, 16'd0, 16'd0, 16'h1234, 16'hFF80, 8'h55);
        push_term();
        send(3'd4, 16'd0, 16'd0, 16'h1234, 16'hFF80, 8'h55, 1'b1);
        wait_done(300, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL poly_kick_done_timeout: done=%b, required 1 within 300 cycles", done);
        end
        finish_kick(cmd0, 1);
    endtask

    task automatic test_overflow();
        force dut.ptr = 18'h3FFF8;
        @(negedge clock);
        release dut.ptr;
        exp_ptr = 18'h3FFF8;
        @(negedge clock);
        checks++;
        if (level !== 17'h1FFF8) begin
            errors++;
            $display("FAIL ovf_preset_level: level=%h, required 1fff8", level);
        end
        send(3'd1, 16'd1, 16'd2, 16'd3, 16'd4, 8'h11, 1'b0);
        checks++;
        if (err_ovf !== 1'b1 || busy !== 1'b0 || level !== 17'h1FFF8) begin
            errors++;
            $display("FAIL ovf_line_reject: err_ovf=%b busy=%b level=%h, required 1 0 1fff8",
                     err_ovf, busy, level);
        end
        send(3'd6, 16'd5, 16'd6, 16'd0, 16'd7, 8'h22, 1'b0);
        checks++;
        if (err_ovf !== 1'b1 || busy !== 1'b0 || level !== 17'h1FFF8) begin
            errors++;
            $display("FAIL ovf_circle_reject: err_ovf=%b busy=%b level=%h, required 1 0 1fff8",
                     err_ovf, busy, level);
        end
        push_pkt(3'd4, 16'd0, 16'd0, 16'h00AB, 16'h8001, 8'h33);
        send(3'd4, 16'd0, 16'd0, 16'h00AB, 16'h8001, 8'h33, 1'b0);
        repeat (6) @(negedge clock);
        checks++;
        if (level !== 17'h1FFFE || err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_poly_accept: level=%h err_ovf=%b, required 1fffe 1", level, err_ovf);
        end
        do_kick(1'b1);
    endtask

    task automatic test_bad_op();
        send(3'd7, 16'd1, 16'd2, 16'd3, 16'd4, 8'h44, 1'b0);
        checks++;
        if (err_op !== 1'b1 || busy !== 1'b0 || level !== 17'd0 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL bad_op7: err_op=%b busy=%b level=%0d err_ovf=%b, required 1 0 0 0",
                     err_op, busy, level, err_ovf);
        end
        send(3'd0, 16'd1, 16'd2, 16'd3, 16'd4, 8'h44, 1'b0);
        checks++;
        if (err_op !== 1'b1 || level !== 17'd0) begin
            errors++;
            $display("FAIL bad_op0: err_op=%b level=%0d, required 1 0", err_op, level);
        end
    endtask

    task automatic test_reset_mid_emit();
        push_pkt(3'd2, 16'hFFFF, 16'h0102, 16'h7F00, 16'h0033, 8'hC3);
        send(3'd2, 16'hFFFF, 16'h0102, 16'h7F00, 16'h0033, 8'hC3, 1'b0);
        repeat (2) @(negedge clock);
        #1;
        sb.delete();
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, done, err_ovf, err_op, vd_cmd, own, w, rq.req_ready} !== 8'b0) begin
            errors++;
            $display("FAIL midemit_reset_flags: busy,done,ovf,op,cmd,own,w,ready=%b, required 00000000",
                     {busy, done, err_ovf, err_op, vd_cmd, own, w, rq.req_ready});
        end
        checks++;
        if (a !== 18'h20000 || o !== 8'h00 || level !== 17'd0) begin
            errors++;
            $display("FAIL midemit_reset_bus: a=%h o=%h level=%0d, required 20000 00 0", a, o, level);
        end
        reset_n = 1'b1;
        exp_ptr = ACMD_BASE;
        @(negedge clock);
        do_kick(1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_empty_kick();
        test_line();
        test_circle_kick();
        test_poly_with_kick();
        test_overflow();
        test_bad_op();
        test_reset_mid_emit();
        repeat (2) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: pending=%0d, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vidac_feeder.md
VIDAC_FEEDER -- requirements
Module: vidac_feeder

Interface
REQ-001 SHALL have ports: clock  in  1  system clock; reset_n  in  1  synchronous, active-low reset.
REQ-002 SHALL have host ports: req_valid in 1; req_ready out 1; req_op in 3 (opcode); req_x1, req_y1, req_x2, req_y2 in 16 each (signed words); req_c in 8 (colour).
REQ-003 SHALL have control ports: kick in 1 (submit list); busy out 1; done out 1 (1-cycle pulse); err_ovf out 1 (sticky); err_op out 1 (sticky); level out 17 (queued bytes).
REQ-004 SHALL have accelerator ports: vd_cmd out 1 (start pulse); vd_bsy in 1 (accelerator busy); own out 1 (feeder drives shared video memory).
REQ-005 SHALL have memory ports: a out 18 (byte address); o out 8 (write data); w out 1 (write strobe). There is no read port.

Function
REQ-006 SHALL build a command list in command memory starting at 0x20000 and write ptr holding the next free address.
REQ-007 SHALL accept a request when req_valid && req_ready; req_ready=1 only in IDLE with no kick pending.
REQ-008 SHALL encode each request as an opcode byte, then words low byte first, then colour:
- op 1/2/3 (LINE, BLOCK, BLOCK_FILL): x1, y1, x2, y2, c; 10 bytes.
- op 4 (POLY): x2, y2, c; 6 bytes.
- op 5/6 (CIRCLE, CIRCLE_FILL): x1=cx, y1=cy, y2=r, c; 8 bytes.
REQ-009 SHALL reject op 0 and op 7 (BLOCK_TEX is unsupported): set err_op, write nothing, consume the request in one cycle.
REQ-010 SHALL reject a request when ptr+len > 0x3FFFF, which reserves one terminator byte: set err_ovf, write nothing, consume the request.
REQ-011 SHALL write accepted bytes as one byte per cycle in EMIT:
- a=ptr, o=byte, w=1, ptr increments.
- First write occurs the cycle after acceptance.
- Request fields are latched at acceptance.
REQ-012 SHALL hold level = ptr-0x20000 at all times.
REQ-013 SHALL latch kick into kick_pend in any state except WAITB/WAITD, where kick is ignored.
REQ-014 SHALL, from IDLE with kick_pend and level=0: clear kick_pend, pulse done next cycle, issue no vd_cmd.
REQ-015 SHALL, from IDLE with kick_pend and level>0, run the submit sequence:
- TERM: write 0x00 at ptr (one cycle, w=1).
- KICK: vd_cmd=1 for exactly one cycle, own=0.
- WAITB until vd_bsy=1.
- WAITD until vd_bsy=0.
- Then: ptr=0x20000, clear err_ovf and err_op, pulse done, return to IDLE.
REQ-016 SHALL define the states IDLE, EMIT, TERM, KICK, WAITB, WAITD.
REQ-017 SHALL set own=1 only in EMIT and TERM; w=0 whenever own=0.
REQ-018 SHALL set busy=1 in every state except IDLE.
REQ-019 SHALL serve an accepted request before a kick on the same cycle; the kick is served after EMIT completes.
REQ-020 SHALL never assert vd_cmd while vd_bsy=1.

Reset
REQ-021 SHALL, on reset_n=0 at a clock edge, set:
- state=IDLE, ptr=0x20000, kick_pend=0.
- vd_cmd=0, w=0, o=0, a=0x20000.
- own=0, busy=0, done=0, err_ovf=0, err_op=0.
- req_ready=0 during reset, 1 the first cycle after.
REQ-022 SHALL discard any partial list on reset mid-EMIT or mid-WAITD; the system resets the accelerator concurrently.

Structure
REQ-023 SHALL take opcode constants, ACMD base 0x20000, and per-opcode packet lengths from shared package vidac_pkg, which the accelerator also uses.
REQ-024 SHALL be a single module with no sub-module; byte selection is a package function indexed by (op, byte index).

Verification
REQ-025 LINE x1=10, y1=20, x2=300, y2=5, c=0x0F -> bytes 01 0A 00 14 00 2C 01 05 00 0F at 0x20000..0x20009 on 10 consecutive cycles; level=10.
REQ-026 CIRCLE cx=160, cy=100, r=40, c=4, then kick:
- Bytes 05 A0 00 64 00 28 00 04, then 00 at 0x20008.
- vd_cmd high exactly 1 cycle; model holds vd_bsy 50 cycles.
- done pulse after vd_bsy falls; ptr back to 0x20000.
REQ-027 Kick with empty list -> no memory write, no vd_cmd, done one cycle after latch.
REQ-028 Kick asserted the same cycle as a POLY request -> POLY 6 bytes written first, then terminator, then vd_cmd.
REQ-029 ptr preset so that 8 free bytes remain -> LINE (10 bytes) rejected with err_ovf=1 and no writes; a following CIRCLE (8 bytes) is rejected; a POLY (6 bytes) is accepted; err_ovf clears on completion of the next kick.
REQ-030 op=7 -> err_op=1, no writes; reset asserted mid-EMIT -> all outputs at REQ-021 values the next cycle.
